// File: rtl/counter_arbiter.sv
// Sole owner of the display counter: arbitrates inc/dec requesters against an auto-increment timebase.
// Build option: define COUNTER_ARB_SATURATE_EN to clamp at 0 / 2^WIDTH-1 instead of wrapping.
module counter_arbiter #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode_auto,
    input  logic             hold,
    input  logic             clr_req,
    input  logic             inc_req,
    output logic             inc_ack,
    input  logic             dec_req,
    output logic             dec_ack,
    output logic [WIDTH-1:0] value,
    output logic             tick,
    output logic [1:0]       state
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'b00,
        ST_AUTO   = 2'b01,
        ST_HOLD   = 2'b10
    } state_t;

    state_t           st;
    logic [DIV_W-1:0] div;
    logic             inc_arm;
    logic             dec_arm;

    logic             inc_srv;
    logic             dec_srv;
    logic [DIV_W-1:0] div_wrap;
    logic             auto_tick;
    logic [WIDTH-1:0] val_inc;
    logic [WIDTH-1:0] val_dec;

    assign state = st;

    // Handshake: a requester raises req and holds it until it sees a one-cycle
    // ack; a req is serviced once per assertion, and the arm flag only
    // re-enables service after req has been sampled low at least once.
    always_comb begin
        inc_srv   = (st != ST_HOLD) && !clr_req && inc_req && inc_arm;
        dec_srv   = (st != ST_HOLD) && !clr_req && dec_req && dec_arm;
        div_wrap  = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        // The tick fires on the edge the divider arrives at its last count.
        auto_tick = (st == ST_AUTO) && !clr_req && (div_wrap == DIV_LAST);
`ifdef COUNTER_ARB_SATURATE_EN
        val_inc   = (value == '1) ? value : value + WIDTH'(1);
        val_dec   = (value == '0) ? value : value - WIDTH'(1);
`else
        val_inc   = value + WIDTH'(1);
        val_dec   = value - WIDTH'(1);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= ST_MANUAL;
            div     <= '0;
            inc_arm <= 1'b1;
            dec_arm <= 1'b1;
            inc_ack <= 1'b0;
            dec_ack <= 1'b0;
            tick    <= 1'b0;
            value   <= '0;
        end else begin
            inc_ack <= inc_srv;
            dec_ack <= dec_srv;
            tick    <= auto_tick;

            if (!inc_req)
                inc_arm <= 1'b1;
            else if (inc_srv)
                inc_arm <= 1'b0;

            if (!dec_req)
                dec_arm <= 1'b1;
            else if (dec_srv)
                dec_arm <= 1'b0;

            if (hold) begin
                st <= ST_HOLD;
            end else begin
                case (st)
                    ST_HOLD:   st <= mode_auto ? ST_AUTO : ST_MANUAL;
                    ST_MANUAL: if (mode_auto) st <= ST_AUTO;
                    ST_AUTO:   if (!mode_auto) st <= ST_MANUAL;
                    default:   st <= ST_MANUAL;
                endcase
            end

            // HOLD leaves the divider untouched so AUTO resumes mid-period.
            if (clr_req || st == ST_MANUAL)
                div <= '0;
            else if (st == ST_AUTO)
                div <= div_wrap;

            if (clr_req) begin
                value <= '0;
            end else if (st == ST_AUTO) begin
                if (auto_tick)
                    value <= val_inc;
            end else if (st == ST_MANUAL) begin
                if (inc_srv && !dec_srv)
                    value <= val_inc;
                else if (dec_srv && !inc_srv)
                    value <= val_dec;
            end
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with TICK_DIV=4; a monitor pops expected ack/tick events.
// Expected values follow COUNTER_ARB_SATURATE_EN when the bench is built with it.
module tb_counter_arbiter;

    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int EW       = WIDTH + 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             mode_auto = 1'b0;
    logic             hold = 1'b0;
    logic             clr_req = 1'b0;
    logic             inc_req = 1'b0;
    logic             dec_req = 1'b0;
    logic             inc_ack;
    logic             dec_ack;
    logic [WIDTH-1:0] value;
    logic             tick;
    logic [1:0]       state;

    logic [EW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    counter_arbiter #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_auto (mode_auto),
        .hold      (hold),
        .clr_req   (clr_req),
        .inc_req   (inc_req),
        .inc_ack   (inc_ack),
        .dec_req   (dec_req),
        .dec_ack   (dec_ack),
        .value     (value),
        .tick      (tick),
        .state     (state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired, got 20000 cycles, limit 20000");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Scoreboard monitor: every ack/tick cycle must match the head of exp_q
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] want;
        got = {inc_ack, dec_ack, tick, value};
        if (!reset && (inc_ack || dec_ack || tick)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL event @%0t: got {inc,dec,tick,value}=%b unexpected, required no event", $time, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL event @%0t: got {inc,dec,tick,value}=%b, required %b", $time, got, want);
                end
            end
        end
    end

    // Driver tasks (called right after a negedge)
    task automatic push_exp(input logic ia, input logic da, input logic tk, input int v);
        exp_q.push_back({ia, da, tk, WIDTH'(v)});
    endtask

    task automatic do_req(input logic i, input logic d, input int n);
        inc_req = i;
        dec_req = d;
        repeat (n) @(negedge clk);
        inc_req = 1'b0;
        dec_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic check(input string name, input int actual, input int required);
        n_tests++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, required %0d", name, $time, actual, required);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_value", value, 0);
        check("reset_state", state, 0);
        check("reset_outs", {inc_ack, dec_ack, tick}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single service per req assertion, then a second assertion
        push_exp(1, 0, 0, 1);
        do_req(1, 0, 5);
        check("inc_once_value", value, 1);
        push_exp(1, 0, 0, 2);
        do_req(1, 0, 2);
        check("inc_again_value", value, 2);

        // Up to 7, then simultaneous inc+dec
        for (int i = 3; i <= 7; i++) begin
            push_exp(1, 0, 0, i);
            do_req(1, 0, 1);
        end
        push_exp(1, 1, 0, 7);
        do_req(1, 1, 1);
        check("both_value", value, 7);

        // Down to 0, then the wrap/saturate boundaries
        for (int i = 6; i >= 0; i--) begin
            push_exp(0, 1, 0, i);
            do_req(0, 1, 1);
        end
`ifdef COUNTER_ARB_SATURATE_EN
        push_exp(0, 1, 0, 0);
        do_req(0, 1, 1);
        check("dec_at_zero", value, 0);
        for (int i = 1; i <= 255; i++) begin
            push_exp(1, 0, 0, i);
            do_req(1, 0, 1);
        end
        push_exp(1, 0, 0, 255);
        do_req(1, 0, 1);
        check("inc_at_max", value, 255);
`else
        push_exp(0, 1, 0, 255);
        do_req(0, 1, 1);
        check("dec_at_zero", value, 255);
        push_exp(1, 0, 0, 0);
        do_req(1, 0, 1);
        check("inc_at_max", value, 0);
`endif
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        check("clr_manual", value, 0);

        // AUTO for 12 cycles: ticks after AUTO edges 3, 7, 11
        push_exp(0, 0, 1, 1);
        push_exp(0, 0, 1, 2);
        push_exp(0, 0, 1, 3);
        mode_auto = 1'b1;
        repeat (12) @(negedge clk);
        check("auto_value", value, 3);
        check("auto_state", state, 1);
        @(negedge clk);

        // HOLD with a pending inc: divider frozen at 1, no service
        hold = 1'b1;
        @(negedge clk);
        inc_req = 1'b1;
        repeat (9) @(negedge clk);
        check("hold_value", value, 3);
        check("hold_state", state, 2);
        check("hold_no_ack", inc_ack, 0);
        push_exp(1, 0, 0, 3);
        push_exp(0, 0, 1, 4);
        hold = 1'b0;
        @(negedge clk);
        check("unhold_state", state, 1);
        @(negedge clk);
        inc_req = 1'b0;
        @(negedge clk);
        check("resume_tick", tick, 1);

        // clr on the tick edge with a pending dec
        repeat (3) @(negedge clk);
        clr_req = 1'b1;
        dec_req = 1'b1;
        @(negedge clk);
        check("clr_value", value, 0);
        check("clr_no_tick_ack", {tick, dec_ack}, 0);
        push_exp(0, 1, 0, 0);
        clr_req = 1'b0;
        @(negedge clk);
        dec_req = 1'b0;
        push_exp(0, 0, 1, 1);
        repeat (2) @(negedge clk);
        check("pre_reset_value", value, 1);

        // Asynchronous reset mid-AUTO, between clock edges
        inc_req = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_value", value, 0);
        check("async_state", state, 0);
        check("async_outs", {inc_ack, dec_ack, tick}, 0);
        mode_auto = 1'b0;
        inc_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_state", state, 0);
        check("post_reset_outs", {inc_ack, dec_ack, tick, value}, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Sequencing and arbitration controller for the 8-bit display counter. It is the single owner of the counter value. It shares that value between two handshaked requesters (increment, decrement) and an internal auto-increment timebase, and it supports a hold/freeze mode. It sits between the button edge detectors and the `ledr` / `dec7seg` consumers in the `fpga` top, on `clock_50`.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits.
- `TICK_DIV`, 50_000_000: clock cycles per auto-increment tick; legal range ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: system clock (`clock_50` at top level).
- `reset` input 1: asynchronous, active-high reset.
- `mode_auto` input 1: level; 1 selects auto-increment, 0 selects manual.
- `hold` input 1: level; 1 freezes value and timebase.
- `clr_req` input 1: level; synchronous clear of value and timebase.
- `inc_req` input 1: increment request, held high until `inc_ack`.
- `inc_ack` output 1: one-cycle acknowledge of `inc_req`.
- `dec_req` input 1: decrement request, held high until `dec_ack`.
- `dec_ack` output 1: one-cycle acknowledge of `dec_req`.
- `value` output WIDTH: current counter value, registered.
- `tick` output 1: one-cycle pulse on each auto increment.
- `state` output 2: FSM state; 00 MANUAL, 01 AUTO, 10 HOLD.

## Operation
- Reset values: `value`=0, `state`=MANUAL, `inc_ack`=`dec_ack`=`tick`=0, divider=0, both arm flags=1.
- FSM, evaluated on each edge:
  - Any state with `hold`=1 goes to HOLD.
  - HOLD with `hold`=0 goes to AUTO if `mode_auto`, else MANUAL.
  - MANUAL with `mode_auto`=1 goes to AUTO.
  - AUTO with `mode_auto`=0 goes to MANUAL.
- The divider counts 0..`TICK_DIV`-1 only in AUTO. It is forced to 0 in MANUAL, on `clr_req`, and on AUTO entry. It is frozen in HOLD and resumes from the frozen count.
- In AUTO, at terminal count: `tick`=1, `value`+1, divider returns to 0.
- Handshake:
  - A request is serviced when its req=1 and its arm flag=1.
  - Service pulses the ack for one cycle and clears the arm flag.
  - The arm flag is set again on any edge where the req is sampled 0.
  - Result: exactly one service per req assertion, even if the requester holds req high for several cycles after ack.
- MANUAL: a serviced inc adds 1; a serviced dec subtracts 1.
- Simultaneous inc and dec serviced in the same cycle: both acked, `value` unchanged.
- AUTO: inc/dec are serviced (acked, arm cleared) but discarded; `value` is changed only by tick. This prevents requester stall.
- HOLD: no service. Requests stay pending, acks stay 0, and requests are serviced on the first edge after leaving HOLD.
- `clr_req`=1 in any state, HOLD included: `value`←0 and divider←0. It has priority over tick, inc and dec. Pending inc/dec are not acked while `clr_req`=1.
- Arithmetic is modulo 2^WIDTH: 255+1→0, 0−1→255. See Configuration for saturation.

## Timing
- Everything is registered; there is no combinational path from input to output.
- A req sampled high at edge k (state, arm and clr permitting) gives the ack and the updated `value` both valid after edge k, for exactly one cycle of ack. Latency is 1 cycle.
- `tick` and its increment appear after the same edge at which the divider reaches `TICK_DIV`-1.
- A state change takes effect on the edge that samples the mode/hold input. Service decisions on that edge use the old state.
- `reset` asserted mid-operation returns all outputs to their reset values immediately, with no clock required. Release must be synchronous to `clk` (handled by the top-level reset generator).

## Configuration
- `COUNTER_ARB_SATURATE_EN`:
  - Defined: inc at 2^WIDTH−1 and dec at 0 leave `value` unchanged but are still acked. An auto tick at 2^WIDTH−1 still pulses `tick` while `value` stays at 2^WIDTH−1.
  - Undefined: modulo wrap as above.

## Test plan
- Reset, MANUAL, hold `inc_req`=1 for 5 cycles → single `inc_ack` one cycle after assertion, `value`=1. Drop and reassert → `value`=2.
- Assert `inc_req` and `dec_req` on the same edge from `value`=7 → both acks pulse, `value`=7.
- `TICK_DIV`=4, `mode_auto`=1 for 12 cycles → `tick` pulses every 4th cycle, `value`=3.
- AUTO, assert `hold` for 10 cycles with `inc_req`=1 → `value` frozen, no ack. Release → divider resumes from frozen count and inc is acked with no value change.
- `value`=255, inc in MANUAL → 0 without macro, 255 with `COUNTER_ARB_SATURATE_EN`. `value`=0, dec → 255 / 0.
- `clr_req` coinciding with tick and pending `dec_req`; then async `reset` mid-AUTO → `value`=0, no tick, no ack; after reset: `state`=00, all outputs 0.
